// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key-press transmit scheduler:
// TX FSM state encoding, line-ending characters and drop counter helpers.
package key_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_CR      = 3'd4,
        ST_LF      = 3'd5
    } tx_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Saturating increment so the lost-press count never wraps back to zero.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/key_sched_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and registered full/empty/level
// flags, so downstream logic only ever sees flop outputs.
module key_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   level_next;

    assign rdata = mem[rptr[AW-1:0]];

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        case ({push, pop})
            2'b10:   level_next = level + ONE;
            2'b01:   level_next = level - ONE;
            default: level_next = level;
        endcase
    end

    // Storage array: write only, contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
            level <= level_next;
            full  <= (level_next == FULL);
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/key_tx_sched.sv
// Round-robin key press arbiter feeding a byte FIFO and the UART TX handshake.
// Optional KEY_TX_CRLF_EN appends CR and LF after every key character.
module key_tx_sched
    import key_sched_pkg::*;
#(
    parameter int          NKEY       = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  BASE_CHAR  = 8'h30,
    parameter int          BUSY_TMO   = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NKEY-1:0]               key_pulse,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt
);
    localparam int KW = (NKEY > 1) ? $clog2(NKEY) : 1;
    localparam int TW = $clog2(BUSY_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

    logic [NKEY-1:0] pend;
    logic [KW-1:0]   rr_ptr;
    logic [KW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            gnt;
    logic [NKEY-1:0] gnt_onehot;
    logic            drop_hit;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [7:0]      fifo_rdata;
    logic [7:0]      key_char;

    tx_state_t       state;
    tx_state_t       done_state;
    logic [TW-1:0]   tmo_cnt;
`ifdef KEY_TX_CRLF_EN
    logic [1:0]      phase;
`endif

    // Scan downward so the last hit is the first pending key at or after rr_ptr.
    always_comb begin
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = NKEY - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NKEY;
            if (pend[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = KW'(j);
            end else begin
                gnt_found = gnt_found;
            end
        end
    end

    assign gnt      = gnt_found & ~fifo_full;
    assign key_char = BASE_CHAR + 8'(gnt_idx);
    assign drop_hit = |(key_pulse & pend & ~gnt_onehot);
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

    // One-hot of the granted key, used to clear its pending bit.
    always_comb begin
        gnt_onehot = '0;
        if (gnt) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end else begin
            gnt_onehot = '0;
        end
    end

    // Pending set, round-robin pointer and lost-press counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend     <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            pend <= (pend & ~gnt_onehot) | key_pulse;
            if (gnt) begin
                rr_ptr <= (int'(gnt_idx) == NKEY - 1) ? '0 : gnt_idx + KW'(1);
            end
            if (drop_hit) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    key_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt),
        .pop   (fifo_pop),
        .wdata (key_char),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Where a finished (or timed-out) byte leads: straight back to IDLE,
    // or on through the CR and LF characters.
    always_comb begin
`ifdef KEY_TX_CRLF_EN
        case (phase)
            2'd0:    done_state = ST_CR;
            2'd1:    done_state = ST_LF;
            default: done_state = ST_IDLE;
        endcase
`else
        done_state = ST_IDLE;
`endif
    end

    // TX handshake sequencer; tx_start is a one-cycle registered strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            tmo_cnt  <= '0;
`ifdef KEY_TX_CRLF_EN
            phase    <= 2'd0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data  <= fifo_rdata;
                        tx_start <= 1'b1;
                        state    <= ST_START;
`ifdef KEY_TX_CRLF_EN
                        phase    <= 2'd0;
`endif
                    end
                end
                ST_START: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_LO;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= done_state;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= done_state;
                    end
                end
`ifdef KEY_TX_CRLF_EN
                ST_CR: begin
                    tx_data  <= CHAR_CR;
                    tx_start <= 1'b1;
                    phase    <= 2'd1;
                    state    <= ST_START;
                end
                ST_LF: begin
                    tx_data  <= CHAR_LF;
                    tx_start <= 1'b1;
                    phase    <= 2'd2;
                    state    <= ST_START;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_tx_sched.md
# key_tx_sched

Scheduler between the per-key debouncers and the UART transmitter. Collects one-cycle press pulses from NKEY debounced keys, arbitrates them round-robin into a byte FIFO, and sequences the UART TX handshake so each press is sent as one ASCII character. Owns flow control toward the transmitter and counts presses lost to backlog.

## Interface
- NKEY, 4: number of debounced key inputs (1..8)
- FIFO_DEPTH, 8: byte FIFO depth, power of two, 2..64
- BASE_CHAR, 8'h30: character sent for key 0; key i sends BASE_CHAR+i (8-bit wrap)
- BUSY_TMO, 15: cycles to wait for tx_busy to rise after tx_start
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- key_pulse  in  NKEY  one-cycle press pulses from debouncers, any combination per cycle
- tx_data  out  8  byte to UART TX, stable from tx_start until the FSM returns to IDLE
- tx_start  out  1  one-cycle start strobe to UART TX
- tx_busy  in  1  UART TX busy
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_cnt  out  8  saturating count of lost presses

## Operation
- Pending register pend[NKEY-1:0]: pend |= key_pulse each cycle; the granted bit is cleared on the same edge; a new pulse on the granted key in the grant cycle re-sets that bit.
- Drop: a pulse on key i while pend[i] is already set and not granted that cycle increments drop_cnt, saturating at 255. Several same-cycle drops count as one increment.
- Arbiter: when pend != 0 and FIFO not full (registered full flag), grant exactly one key: the lowest index >= rr_ptr, wrapping; then rr_ptr <= grant+1 mod NKEY. The granted byte is written to the FIFO on that edge. No grant while full; pend holds.
- FIFO: simultaneous push and pop permitted at any level; pop of empty and push of full never occur.
- TX FSM states: IDLE, START, WAIT_HI, WAIT_LO.
  - IDLE: if FIFO non-empty, pop, register tx_data, go to START.
  - START: tx_start=1 for this cycle only; go to WAIT_HI.
  - WAIT_HI: tx_busy=1 goes to WAIT_LO; after BUSY_TMO cycles without busy, go to IDLE (byte treated as sent).
  - WAIT_LO: tx_busy=0 goes to IDLE.
- Reset, including mid-transfer: pend=0, rr_ptr=0, FIFO empty, FSM=IDLE, tx_start=0, tx_data=0, fifo_level=0, drop_cnt=0. A byte in flight in the UART is not tracked after reset.

## Timing
- Pulse sampled at edge E0, pend set. Grant and FIFO write occur at E1. IDLE pop occurs at E2. tx_start is high in the cycle after E2. This is 3 cycles pulse-to-start when idle and empty.
- Back-to-back bytes: minimum 1 IDLE cycle between the tx_busy fall and the next tx_start.
- fifo_level updates on the edge of push or pop; it is net 0 on a simultaneous push and pop.
- All outputs are registered.

## Configuration
- KEY_TX_CRLF_EN:
  - Defined: after each key byte, the FSM sends 8'h0D and then 8'h0A, each with its own START/WAIT_HI/WAIT_LO handshake, via added states CR and LF, before returning to IDLE. The FIFO pops only the key byte.
  - Undefined: one byte per press; the CR and LF states are absent.

## Structure
- Package key_sched_pkg holds:
  - the FSM state enum, including CR and LF
  - CHAR_CR=8'h0D and CHAR_LF=8'h0A
  - the drop_cnt width constant
- Sub-module key_sched_fifo: synchronous FIFO with push, pop, wdata, rdata, full, empty and level. Pointers carry an extra wrap bit.
- Arbiter and FSM live in the top module.

## Test plan
- Single press on key 2, UART model busy for 10 cycles -> tx_start high 3 cycles after the pulse, tx_data=8'h32, FSM back in IDLE 1 cycle after busy falls.
- key_pulse=4'b1111 in one cycle -> bytes 30,31,32,33 sent in that order. Next simultaneous burst with last grant=3 -> again starts at 30.
- Key 1 pulsed twice while pend[1] is held by a full FIFO -> drop_cnt=1, and exactly one 8'h31 is sent after the FIFO drains.
- 300 dropped presses -> drop_cnt saturates at 255.
- tx_busy stuck low -> FSM leaves WAIT_HI after 15 cycles, and the next byte starts normally.
- Reset asserted in WAIT_LO with 3 bytes queued -> all outputs 0, fifo_level=0, no further tx_start. With KEY_TX_CRLF_EN, a key 0 press yields 30,0D,0A.
